pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 64: maximum number of wait cycles allowed for data memory before an error is flagged.
REQ-003 SHALL have one clock and a synchronous, active-high reset. The clock is named clk and the reset is named reset.
REQ-004 Ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high reset.
- id_rs1, in, 5: rs1 of the instruction in decode.
- id_rs2, in, 5: rs2 of the instruction in decode.
- id_use1, in, 1: decode instruction reads rs1.
- id_use2, in, 1: decode instruction reads rs2.
- ex_memread, in, 1: the instruction in execute is a load.
- ex_rd, in, 5: destination register of the instruction in execute.
- mem_taken, in, 1: a branch or jump resolved as taken in the mem stage.
- mem_req, in, 1: the mem-stage instruction accesses data memory.
- mem_ready, in, 1: data memory completes the access this cycle.
- pcwrite, out, 1: PC register enable.
- fdwrite, out, 1: fetch/decode register enable.
- fd_flush, out, 1: load NOP into fetch/decode.
- de_bubble, out, 1: zero all control fields entering decode/execute.
- em_flush, out, 1: zero the control fields entering exec/mem.
- hold, out, 1: freeze the decode/execute, exec/mem and mem/writeback registers.
- mem_err, out, 1: sticky memory-timeout flag.
- stall_cnt, out, CNT_W: count of stall cycles.
- flush_cnt, out, CNT_W: count of taken-branch flush events.

Function
REQ-005 SHALL implement a 2-state FSM with states RUN and WAIT.
REQ-006 Control outputs (pcwrite, fdwrite, fd_flush, de_bubble, em_flush, hold) SHALL be combinational from the current state and inputs, and take effect in the same cycle. Counters and mem_err SHALL be registered.
REQ-007 The load-use hazard SHALL be defined as: RUN, ex_memread=1, ex_rd!=0, and ((id_use1 and id_rs1==ex_rd) or (id_use2 and id_rs2==ex_rd)).
REQ-008 In RUN with no event: pcwrite=1, fdwrite=1, and all other control outputs 0.
REQ-009 In RUN with a load-use hazard only: pcwrite=0, fdwrite=0, de_bubble=1 for exactly one cycle. stall_cnt SHALL increment by 1.
REQ-010 In RUN with mem_taken=1 and mem_req=0 or mem_ready=1: pcwrite=1, fdwrite=1, fd_flush=1, de_bubble=1, em_flush=1. flush_cnt SHALL increment by 1. A coincident load-use hazard SHALL be ignored.
REQ-011 In RUN with mem_req=1 and mem_ready=0:
- The FSM SHALL go to WAIT.
- That cycle: pcwrite=0, fdwrite=0, hold=1, no flush outputs.
- mem_taken SHALL be latched into pend_taken.
- The wait counter SHALL be set to 1.
- stall_cnt SHALL increment by 1.
REQ-012 In WAIT with mem_ready=0: pcwrite=0, fdwrite=0, hold=1. The wait counter and stall_cnt SHALL increment by 1.
REQ-013 When the wait counter reaches MEM_TIMEOUT in WAIT, mem_err SHALL set to 1 and remain set until reset. The FSM SHALL stay in WAIT.
REQ-014 In WAIT with mem_ready=1:
- The FSM SHALL return to RUN.
- That cycle's outputs SHALL be those of RUN evaluated with mem_taken replaced by (mem_taken or pend_taken).
- pend_taken SHALL clear.
REQ-015 Priority SHALL be reset > memory wait > taken flush > load-use.
REQ-016 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 The wait counter SHALL saturate at MEM_TIMEOUT.

Reset
REQ-018 On clk edge with reset=1, the block SHALL set:
- state to RUN;
- pend_taken, the wait counter, stall_cnt, flush_cnt and mem_err to 0.
REQ-019 Control outputs during a reset cycle SHALL be: pcwrite=0, fdwrite=0, fd_flush=1, de_bubble=1, em_flush=1, hold=0.
REQ-020 Reset asserted in WAIT SHALL abandon the pending access and discard pend_taken.

Structure
REQ-021 The state enum and the default parameter values SHALL live in the shared package pipe_pkg.
REQ-022 The load-use comparator SHALL be a separate combinational sub-module, hazard_detect. The FSM, counters and output decode SHALL remain in pipe_ctrl.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use2=1 -> one cycle of pcwrite=0, fdwrite=0, de_bubble=1; stall_cnt becomes 1.
- Load into x0: ex_rd=0, id_rs1=0, id_use1=1 -> no stall; pcwrite=1.
- Taken branch: mem_taken=1 -> fd_flush, de_bubble and em_flush all 1 for one cycle; flush_cnt becomes 1.
- Memory wait with deferred branch: mem_req=1, mem_ready low for 3 cycles, mem_taken=1 on the first cycle -> 3 cycles with hold=1; flush applied on the mem_ready cycle; stall_cnt becomes 3.
- Timeout: MEM_TIMEOUT=4, mem_ready held low -> mem_err rises after the 4th wait cycle and stays 1 after mem_ready.
- Reset in WAIT: assert reset on the 2nd wait cycle -> next state RUN; all counters 0; no flush fires when mem_ready later arrives.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default parameters for the pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;
    localparam int unsigned REG_W           = 5;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the decode instruction reads a register that the
// load currently in execute has not yet produced. x0 never hazards.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use_c
);

    // Match either live source operand against a non-zero load destination
    always_comb begin
        load_use_c = ex_memread && (ex_rd != '0) &&
                     ((id_use1 && (id_rs1 == ex_rd)) ||
                      (id_use2 && (id_rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes,
// data-memory wait holds with timeout, and saturating performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             fdwrite,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             em_flush,
    output logic             hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic                pend_taken_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_q;
    logic                mem_err_q;
    logic                load_use_c;
    logic                taken_eff;
    logic                enter_wait;
    logic                wait_inc;
    logic                stall_inc;
    logic                flush_inc;
    logic                err_set;

    hazard_detect u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use1    (id_use1),
        .id_use2    (id_use2),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use_c (load_use_c)
    );

    // Next state and same-cycle control decode; priority reset > mem wait > flush > load-use
    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b1;
        fdwrite    = 1'b1;
        fd_flush   = 1'b0;
        de_bubble  = 1'b0;
        em_flush   = 1'b0;
        hold       = 1'b0;
        enter_wait = 1'b0;
        wait_inc   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        taken_eff  = mem_taken || ((state_q == WAIT) && pend_taken_q);
        if (reset) begin
            pcwrite   = 1'b0;
            fdwrite   = 1'b0;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            em_flush  = 1'b1;
            state_d   = RUN;
        end else if ((state_q == WAIT) && !mem_ready) begin
            pcwrite   = 1'b0;
            fdwrite   = 1'b0;
            hold      = 1'b1;
            wait_inc  = 1'b1;
            stall_inc = 1'b1;
        end else if ((state_q == RUN) && mem_req && !mem_ready) begin
            pcwrite    = 1'b0;
            fdwrite    = 1'b0;
            hold       = 1'b1;
            enter_wait = 1'b1;
            stall_inc  = 1'b1;
            state_d    = WAIT;
        end else begin
            // Plain RUN, or the WAIT cycle where memory completes (deferred branch folded in)
            state_d = RUN;
            if (taken_eff) begin
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
                em_flush  = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use_c) begin
                pcwrite   = 1'b0;
                fdwrite   = 1'b0;
                de_bubble = 1'b1;
                stall_inc = 1'b1;
            end
        end
    end

    // Saturating wait-cycle count and timeout detection
    always_comb begin
        if (enter_wait) begin
            wait_nxt = WAIT_W'(1);
        end else if (wait_cnt_q == WAIT_MAX) begin
            wait_nxt = wait_cnt_q;
        end else begin
            wait_nxt = wait_cnt_q + WAIT_W'(1);
        end
        err_set = (enter_wait || wait_inc) && (wait_nxt == WAIT_MAX);
    end

    // State, pending branch, wait counter, performance counters and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pend_taken_q <= 1'b0;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enter_wait) begin
                pend_taken_q <= mem_taken;
            end else if (!wait_inc) begin
                pend_taken_q <= 1'b0;
            end
            wait_cnt_q <= (enter_wait || wait_inc) ? wait_nxt : '0;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (err_set) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;

endmodule
